// File: rtl/wb_gpio_bank_if.sv
// Wishbone slave bus bundle for wb_gpio_bank; signal names follow the
// Caravel-style wbs_* naming so wrappers can hook it straight to the SoC bus.
interface wb_gpio_bank_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_gpio_bank.sv
// Wishbone GPIO bank: software-driven pad outputs/enables, synchronised inputs,
// per-pin edge detection with W1C status and a masked level interrupt.
module wb_gpio_bank #(
    parameter int          NUM_GPIO      = 38,
    parameter logic [63:0] RESERVED_MASK = 64'h1E,
    parameter int          SYNC_STAGES   = 2,
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    wb_gpio_bank_if.slave       wbs,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oeb,
    output logic                irq
);
    // Shift by 64 yields 0, so the subtraction still gives all ones for 64 pads.
    localparam logic [63:0] PAD_MASK    = (64'd1 << NUM_GPIO) - 64'd1;
    localparam logic [63:0] ACTIVE_MASK = PAD_MASK & ~RESERVED_MASK;

    localparam logic [2:0] REG_OUT = 3'd0;
    localparam logic [2:0] REG_OEB = 3'd1;
    localparam logic [2:0] REG_IN  = 3'd2;
    localparam logic [2:0] REG_IE  = 3'd3;
    localparam logic [2:0] REG_IS  = 3'd4;
    localparam logic [2:0] REG_POL = 3'd5;

    logic [63:0] out_reg, out_next;
    logic [63:0] oeb_reg, oeb_next;
    logic [63:0] ie_reg, ie_next;
    logic [63:0] is_reg, is_next;
    logic [63:0] pol_reg, pol_next;
    logic [63:0] sync_reg [SYNC_STAGES];
    logic [63:0] p_reg;
    logic        ack_reg;
    logic [31:0] dat_reg;
    logic        irq_reg;

    logic        hit;
    logic        in_map;
    logic        word_hi;
    logic [2:0]  reg_idx;
    logic [31:0] byte_mask;
    logic [63:0] wr_mask;
    logic [63:0] wr_data;
    logic [63:0] gpio_ext;
    logic [63:0] sync_s;
    logic [63:0] edge_hit;
    logic [63:0] rd64;
    logic [31:0] rdata;
    logic        unused_bits;

    assign hit     = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_reg &
                     (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign reg_idx = wbs.wbs_adr_i[5:3];
    assign word_hi = wbs.wbs_adr_i[2];
    assign in_map  = (wbs.wbs_adr_i[7:6] == 2'b00) && (reg_idx <= REG_POL);
    assign unused_bits = ^wbs.wbs_adr_i[1:0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            assign byte_mask[gi*8 +: 8] = {8{wbs.wbs_sel_i[gi]}};
        end
    endgenerate

    assign wr_mask = word_hi ? {byte_mask, 32'h0} : {32'h0, byte_mask};
    assign wr_data = {wbs.wbs_dat_i, wbs.wbs_dat_i};

    function automatic logic [63:0] merge(input logic [63:0] old,
                                          input logic [63:0] mask,
                                          input logic [63:0] data);
        return ((old & ~mask) | (data & mask)) & ACTIVE_MASK;
    endfunction

    always_comb begin
        gpio_ext = '0;
        gpio_ext[NUM_GPIO-1:0] = gpio_in;
    end

    assign sync_s   = sync_reg[SYNC_STAGES-1];
    // Reserved pads are masked at the synchroniser input, so they can never raise IS.
    assign edge_hit = (((sync_s & ~p_reg) & ~pol_reg) |
                       ((~sync_s & p_reg) & pol_reg)) & ACTIVE_MASK;

    always_comb begin
        out_next = out_reg;
        oeb_next = oeb_reg;
        ie_next  = ie_reg;
        pol_next = pol_reg;
        is_next  = is_reg | edge_hit;
        if (hit && wbs.wbs_we_i && in_map) begin
            case (reg_idx)
                REG_OUT: out_next = merge(out_reg, wr_mask, wr_data);
                REG_OEB: oeb_next = merge(oeb_reg, wr_mask, wr_data);
                REG_IE:  ie_next  = merge(ie_reg, wr_mask, wr_data);
                REG_POL: pol_next = merge(pol_reg, wr_mask, wr_data);
                // A fresh edge in the clearing cycle keeps the bit set.
                REG_IS:  is_next  = (is_reg & ~(wr_data & wr_mask)) | edge_hit;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd64 = '0;
        case (reg_idx)
            REG_OUT: rd64 = out_reg;
            REG_OEB: rd64 = oeb_reg;
            REG_IN:  rd64 = sync_s;
            REG_IE:  rd64 = ie_reg;
            REG_IS:  rd64 = is_reg;
            REG_POL: rd64 = pol_reg;
            default: rd64 = '0;
        endcase
        rdata = '0;
        if (in_map) begin
            rdata = word_hi ? rd64[63:32] : rd64[31:0];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_reg <= '0;
            oeb_reg <= ACTIVE_MASK;
            ie_reg  <= '0;
            is_reg  <= '0;
            pol_reg <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
            p_reg   <= '0;
            ack_reg <= 1'b0;
            dat_reg <= '0;
            irq_reg <= 1'b0;
        end else begin
            out_reg <= out_next;
            oeb_reg <= oeb_next;
            ie_reg  <= ie_next;
            is_reg  <= is_next;
            pol_reg <= pol_next;
            sync_reg[0] <= gpio_ext & ACTIVE_MASK;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            p_reg   <= sync_s;
            ack_reg <= hit;
            dat_reg <= (hit && !wbs.wbs_we_i) ? rdata : 32'h0;
            irq_reg <= |(is_reg & ie_reg & ACTIVE_MASK);
        end
    end

    assign gpio_out      = out_reg[NUM_GPIO-1:0] & ~RESERVED_MASK[NUM_GPIO-1:0];
    assign gpio_oeb      = oeb_reg[NUM_GPIO-1:0] | RESERVED_MASK[NUM_GPIO-1:0];
    assign irq           = irq_reg;
    assign wbs.wbs_ack_o = ack_reg;
    assign wbs.wbs_dat_o = dat_reg;
endmodule

// File: tb/tb_wb_gpio_bank.sv
// Self-checking bench for wb_gpio_bank (38 pads, pads 4:1 reserved, 2-stage sync).
module tb_wb_gpio_bank;
    localparam int          NUM_GPIO = 38;
    localparam logic [31:0] LO_ACT   = 32'hFFFF_FFE1;
    localparam logic [31:0] HI_ACT   = 32'h0000_003F;
    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam logic [31:0] OUT_LO = BASE + 32'h00, OUT_HI = BASE + 32'h04;
    localparam logic [31:0] OEB_LO = BASE + 32'h08, OEB_HI = BASE + 32'h0C;
    localparam logic [31:0] IN_LO  = BASE + 32'h10;
    localparam logic [31:0] IE_LO  = BASE + 32'h18, IE_HI  = BASE + 32'h1C;
    localparam logic [31:0] IS_LO  = BASE + 32'h20;
    localparam logic [31:0] POL_LO = BASE + 32'h28, POL_HI = BASE + 32'h2C;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NUM_GPIO-1:0] gpio_in = '0;
    logic [NUM_GPIO-1:0] gpio_out;
    logic [NUM_GPIO-1:0] gpio_oeb;
    logic                irq;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    wb_gpio_bank_if bus ();

    wb_gpio_bank #(
        .NUM_GPIO(NUM_GPIO), .RESERVED_MASK(64'h1E), .SYNC_STAGES(2), .BASE_ADDR(BASE)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_idle();
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_dat_i = '0;   bus.wbs_adr_i = '0;
    endtask

    task automatic xfer(input logic wr, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic acked, output logic [31:0] rdata,
                        output int lat, output logic ack_after);
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = wr;
        bus.wbs_sel_i = sel;  bus.wbs_dat_i = dat;  bus.wbs_adr_i = adr;
        acked = 1'b0; rdata = '0; lat = 0;
        while (!acked && lat < 4) begin
            @(posedge clk); #1;
            lat++;
            if (bus.wbs_ack_o) begin
                acked = 1'b1;
                rdata = bus.wbs_dat_o;
            end
        end
        bus_idle();
        @(posedge clk); #1;
        ack_after = bus.wbs_ack_o;
        $display("%s adr=%h dat=%h sel=%b ack=%0d lat=%0d rdata=%h",
                 wr ? "WR" : "RD", adr, dat, sel, acked, lat, rdata);
    endtask

    task automatic test_reset();
        logic [31:0] adrs [5];
        logic acked, aa; logic [31:0] d, e; int lat;
        adrs = '{OEB_LO, OEB_HI, OUT_LO, IE_LO, IS_LO};
        bus_idle();
        rst = 1'b1; gpio_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        vectors++;
        if (gpio_oeb !== '1) begin
            miscompares++; $display("FAIL reset_oeb got=%h exp=all-ones", gpio_oeb);
        end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got=%b exp=0", irq); end
        exp_q.push_back(LO_ACT); exp_q.push_back(HI_ACT);
        exp_q.push_back(32'h0);  exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        foreach (adrs[i]) begin
            xfer(1'b0, adrs[i], 32'h0, 4'hF, acked, d, lat, aa);
            e = exp_q.pop_front();
            vectors++;
            if (!acked || d !== e) begin
                miscompares++;
                $display("FAIL reset_read adr=%h got=%h exp=%h ack=%0d", adrs[i], d, e, acked);
            end
        end
    endtask

    task automatic test_write_sel();
        logic acked, aa; logic [31:0] d, e; int lat;
        xfer(1'b1, OUT_LO, 32'hFFFF_FFFF, 4'b0011, acked, d, lat, aa);
        vectors++;
        if (!acked || lat != 1 || aa !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_timing got ack=%0d lat=%0d after=%b exp ack=1 lat=1 after=0", acked, lat, aa);
        end
        xfer(1'b1, OEB_LO, 32'h0, 4'hF, acked, d, lat, aa);
        exp_q.push_back(32'h0000_FFE1);
        xfer(1'b0, OUT_LO, 32'h0, 4'hF, acked, d, lat, aa);
        e = exp_q.pop_front();
        vectors++;
        if (!acked || d !== e) begin
            miscompares++; $display("FAIL out_lo_sel got=%h exp=%h", d, e);
        end
        vectors++;
        if (gpio_out !== {22'h0, 16'hFFE1}) begin
            miscompares++; $display("FAIL gpio_out got=%h exp=%h", gpio_out, {22'h0, 16'hFFE1});
        end
        vectors++;
        if (gpio_oeb !== {6'h3F, 32'h0000_001E}) begin
            miscompares++; $display("FAIL gpio_oeb got=%h exp=%h", gpio_oeb, {6'h3F, 32'h1E});
        end
    endtask

    task automatic test_edge_irq();
        logic acked, aa; logic [31:0] d, e; int lat;
        xfer(1'b1, IE_LO, 32'h80, 4'hF, acked, d, lat, aa);
        @(negedge clk); gpio_in[7] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (irq !== (k >= 4)) begin
                miscompares++; $display("FAIL irq_latency edge=%0d got=%b exp=%b", k, irq, k >= 4);
            end
        end
        exp_q.push_back(32'h80); exp_q.push_back(32'h80);
        xfer(1'b0, IN_LO, 32'h0, 4'hF, acked, d, lat, aa);
        e = exp_q.pop_front(); vectors++;
        if (!acked || d !== e) begin miscompares++; $display("FAIL in_lo got=%h exp=%h", d, e); end
        xfer(1'b0, IS_LO, 32'h0, 4'hF, acked, d, lat, aa);
        e = exp_q.pop_front(); vectors++;
        if (!acked || d !== e) begin miscompares++; $display("FAIL is_rise got=%h exp=%h", d, e); end
        xfer(1'b1, IS_LO, 32'h80, 4'hF, acked, d, lat, aa);
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_w1c got=%b exp=0", irq); end
        exp_q.push_back(32'h0);
        xfer(1'b0, IS_LO, 32'h0, 4'hF, acked, d, lat, aa);
        e = exp_q.pop_front(); vectors++;
        if (!acked || d !== e) begin miscompares++; $display("FAIL is_cleared got=%h exp=%h", d, e); end
    endtask

    task automatic test_falling_pol();
        logic acked, aa; logic [31:0] d, e; int lat;
        xfer(1'b1, POL_LO, 32'h200, 4'hF, acked, d, lat, aa);
        xfer(1'b1, IE_LO, 32'h280, 4'hF, acked, d, lat, aa);
        @(negedge clk); gpio_in[9] = 1'b1;
        repeat (5) @(posedge clk);
        exp_q.push_back(32'h0);
        xfer(1'b0, IS_LO, 32'h0, 4'hF, acked, d, lat, aa);
        e = exp_q.pop_front(); vectors++;
        if (!acked || d !== e || irq !== 1'b0) begin
            miscompares++; $display("FAIL pol_rise_ignored got=%h irq=%b exp=%h irq=0", d, irq, e);
        end
        @(negedge clk); gpio_in[9] = 1'b0;
        repeat (5) @(posedge clk);
        exp_q.push_back(32'h200);
        xfer(1'b0, IS_LO, 32'h0, 4'hF, acked, d, lat, aa);
        e = exp_q.pop_front(); vectors++;
        if (!acked || d !== e || irq !== 1'b1) begin
            miscompares++; $display("FAIL pol_fall_sets got=%h irq=%b exp=%h irq=1", d, irq, e);
        end
        xfer(1'b1, IS_LO, 32'h200, 4'hF, acked, d, lat, aa);
        xfer(1'b1, IE_LO, 32'hFFFF_FFFF, 4'hF, acked, d, lat, aa);
        @(negedge clk); gpio_in[2] = 1'b1;
        repeat (5) @(posedge clk);
        exp_q.push_back(32'h80);
        xfer(1'b0, IN_LO, 32'h0, 4'hF, acked, d, lat, aa);
        e = exp_q.pop_front(); vectors++;
        if (!acked || d !== e) begin miscompares++; $display("FAIL in_reserved got=%h exp=%h", d, e); end
        @(negedge clk); gpio_in[2] = 1'b0;
        repeat (5) @(posedge clk);
        exp_q.push_back(32'h0);
        xfer(1'b0, IS_LO, 32'h0, 4'hF, acked, d, lat, aa);
        e = exp_q.pop_front(); vectors++;
        if (!acked || d !== e || irq !== 1'b0) begin
            miscompares++; $display("FAIL reserved_edge got=%h irq=%b exp=%h irq=0", d, irq, e);
        end
    endtask

    task automatic test_w1c_collision();
        logic acked, aa; logic [31:0] d, e; int lat;
        @(negedge clk); gpio_in[7] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); gpio_in[7] = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk); gpio_in[7] = 1'b0;
        repeat (4) @(posedge clk);
        // Rise lands in IS on the second edge after this one: align the W1C hit with it.
        @(negedge clk); gpio_in[7] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        xfer(1'b1, IS_LO, 32'h80, 4'hF, acked, d, lat, aa);
        exp_q.push_back(32'h80);
        xfer(1'b0, IS_LO, 32'h0, 4'hF, acked, d, lat, aa);
        e = exp_q.pop_front(); vectors++;
        if (!acked || d !== e) begin miscompares++; $display("FAIL w1c_set_wins got=%h exp=%h", d, e); end
        xfer(1'b1, IE_LO, 32'h0, 4'hF, acked, d, lat, aa);
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL ie_off_irq got=%b exp=0", irq); end
        xfer(1'b1, IE_LO, 32'h80, 4'hF, acked, d, lat, aa);
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL ie_pending_irq got=%b exp=1", irq); end
    endtask

    task automatic test_reset_mid();
        logic acked, aa; logic [31:0] d, e; int lat;
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_sel_i = 4'hF; bus.wbs_dat_i = 32'h20; bus.wbs_adr_i = OUT_LO;
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus.wbs_ack_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_ack got=%b exp=0", bus.wbs_ack_o);
        end
        bus_idle();
        @(negedge clk); rst = 1'b0;
        exp_q.push_back(32'h0);
        xfer(1'b0, OUT_LO, 32'h0, 4'hF, acked, d, lat, aa);
        e = exp_q.pop_front(); vectors++;
        if (!acked || d !== e) begin miscompares++; $display("FAIL reset_write got=%h exp=%h", d, e); end
        repeat (3) @(posedge clk);
        exp_q.push_back(32'h80);
        xfer(1'b0, IS_LO, 32'h0, 4'hF, acked, d, lat, aa);
        e = exp_q.pop_front(); vectors++;
        if (!acked || d !== e || irq !== 1'b0) begin
            miscompares++; $display("FAIL release_edge got=%h irq=%b exp=%h irq=0", d, irq, e);
        end
        xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, acked, d, lat, aa);
        vectors++;
        if (acked) begin miscompares++; $display("FAIL outside_ack got=1 exp=0"); end
        xfer(1'b1, BASE + 32'h100, 32'hFFFF_FFFF, 4'hF, acked, d, lat, aa);
        exp_q.push_back(32'h0);
        xfer(1'b0, OUT_LO, 32'h0, 4'hF, acked, d, lat, aa);
        e = exp_q.pop_front(); vectors++;
        if (!acked || d !== e) begin miscompares++; $display("FAIL outside_write got=%h exp=%h", d, e); end
        exp_q.push_back(32'h0);
        xfer(1'b0, BASE + 32'hF0, 32'h0, 4'hF, acked, d, lat, aa);
        e = exp_q.pop_front(); vectors++;
        if (!acked || d !== e) begin
            miscompares++; $display("FAIL unmapped_read got=%h ack=%0d exp=%h ack=1", d, acked, e);
        end
    endtask

    task automatic test_back_to_back();
        logic acked, aa; logic [31:0] d, e; int lat; int acks;
        logic [31:0] radr [3];
        radr = '{OUT_HI, POL_HI, IE_HI};
        xfer(1'b1, OUT_HI, 32'hFFFF_FFFF, 4'hF, acked, d, lat, aa); exp_q.push_back(HI_ACT);
        xfer(1'b1, POL_HI, 32'hFFFF_FFFF, 4'hF, acked, d, lat, aa); exp_q.push_back(HI_ACT);
        xfer(1'b1, IE_HI,  32'h0000_A5A5, 4'b0001, acked, d, lat, aa); exp_q.push_back(32'h25);
        foreach (radr[i]) begin
            xfer(1'b0, radr[i], 32'h0, 4'hF, acked, d, lat, aa);
            e = exp_q.pop_front(); vectors++;
            if (!acked || d !== e) begin
                miscompares++; $display("FAIL hi_word adr=%h got=%h exp=%h", radr[i], d, e);
            end
        end
        vectors++;
        if (gpio_out[37:32] !== 6'h3F) begin
            miscompares++; $display("FAIL gpio_out_hi got=%h exp=3f", gpio_out[37:32]);
        end
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = IN_LO;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            e = bus.wbs_ack_o ? 32'h80 : 32'h0;
            if (bus.wbs_ack_o) acks++;
            vectors++;
            if (bus.wbs_ack_o !== (k % 2 == 0) || bus.wbs_dat_o !== ((k % 2 == 0) ? 32'h80 : 32'h0)) begin
                miscompares++;
                $display("FAIL b2b edge=%0d ack=%b dat=%h exp ack=%0d", k, bus.wbs_ack_o, bus.wbs_dat_o, k % 2 == 0);
            end
        end
        bus_idle();
        $display("RD burst adr=%h acks=%0d last=%h", IN_LO, acks, e);
        vectors++;
        if (acks != 4) begin miscompares++; $display("FAIL b2b_count got=%0d exp=4", acks); end
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_write_sel();
        test_edge_irq();
        test_falling_pol();
        test_w1c_collision();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
